// File: rtl/uart_word_tx_if.sv
// -----------------------------------------------------------------------------
// uart_word_tx_if
//
// Purpose:
//   Valid/ready word handshake between a word producer and the uart_word_tx
//   serialiser. The producer owns word_valid and word_data; the serialiser
//   owns word_ready. A word moves on any rising clock edge where
//   word_valid and word_ready are both high.
//
// Signals:
//   word_valid  producer -> consumer  word_data holds a word to send
//   word_data   producer -> consumer  32-bit word to serialise
//   word_ready  consumer -> producer  consumer can take a word this cycle
//
// Modports:
//   master  word producer (drives word_valid, word_data)
//   slave   word consumer (drives word_ready)
// -----------------------------------------------------------------------------
interface uart_word_tx_if;

  logic        word_valid;
  logic [31:0] word_data;
  logic        word_ready;

  modport master (
    output word_valid,
    output word_data,
    input  word_ready
  );

  modport slave (
    input  word_valid,
    input  word_data,
    output word_ready
  );

endinterface : uart_word_tx_if

// File: rtl/uart_word_tx.sv
// -----------------------------------------------------------------------------
// uart_word_tx
//
// Purpose:
//   Serialises 32-bit words onto a UART transmit line as four back-to-back
//   8N1 frames, least-significant byte first. Each bit is held for exactly
//   CYCLES_PER_BIT = CLK_HZ/BIT_RATE clock cycles. A word is accepted through
//   a valid/ready handshake, latched internally, and then sent without regard
//   to later changes on the handshake inputs.
//
// Parameters:
//   CLK_HZ      system clock frequency in Hz
//   BIT_RATE    UART line rate in bits/s
//
// Ports:
//   clk           in   system clock, rising edge
//   rst           in   synchronous, active-high reset
//   uart_tx_en    in   transmit enable; gates acceptance of new words only
//   word_if       --   slave side of the word handshake (valid/data/ready)
//   uart_txd      out  UART transmit pin, idle high (registered)
//   uart_tx_busy  out  a word is in progress
//   byte_done     out  1-cycle pulse on the last cycle of every stop bit
//   word_done     out  1-cycle pulse together with the 4th byte_done
// -----------------------------------------------------------------------------
module uart_word_tx #(
  parameter int CLK_HZ   = 50_000_000,
  parameter int BIT_RATE = 9600
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           uart_tx_en,
  uart_word_tx_if.slave  word_if,
  output logic           uart_txd,
  output logic           uart_tx_busy,
  output logic           byte_done,
  output logic           word_done
);

  // ---------------------------------------------------------------------------
  // Derived constants
  // ---------------------------------------------------------------------------
  localparam int CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
  localparam int CNT_W          = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t           state_q,     state_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;        // cycles within current bit
  logic [2:0]       bit_idx_q,   bit_idx_d;    // data bit within byte, 0..7
  logic [1:0]       byte_idx_q,  byte_idx_d;   // byte within word, 0..3
  logic [31:0]      word_q,      word_d;       // latched word being sent
  logic             txd_q,       txd_d;
  logic             byte_done_q, byte_done_d;
  logic             word_done_q, word_done_d;

  logic             ready;
  logic             accept;
  logic             bit_end;

  // Ready is combinational so a producer holding word_valid high is taken on
  // the first idle cycle; reset masks it so nothing slips in during reset.
  assign ready               = (state_q == IDLE) && uart_tx_en && !rst;
  assign accept              = ready && word_if.word_valid;
  assign bit_end             = (cnt_q == CNT_LAST);
  assign word_if.word_ready  = ready;

  // ---------------------------------------------------------------------------
  // Next-state and output decode
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first so no path through
  // the case statement leaves one unassigned, which would infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    word_d     = word_q;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (accept) begin
          state_d    = START;
          word_d     = word_if.word_data;
          bit_idx_d  = '0;
          byte_idx_d = '0;
        end
      end

      START: begin
        cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
        if (bit_end) begin
          state_d   = DATA;
          bit_idx_d = '0;
        end
      end

      DATA: begin
        cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
        if (bit_end) begin
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end

      STOP: begin
        cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
        if (bit_end) begin
          // Byte index wraps 3 -> 0 on the way back to IDLE.
          byte_idx_d = byte_idx_q + 2'd1;
          state_d    = (byte_idx_q == 2'd3) ? IDLE : START;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered: decode what the line must show in the cycle
    // after this edge, so uart_txd never glitches on state/counter changes.
    unique case (state_d)
      IDLE:    txd_d = 1'b1;
      START:   txd_d = 1'b0;
      DATA:    txd_d = word_d[{byte_idx_d, bit_idx_d}];
      STOP:    txd_d = 1'b1;
      default: txd_d = 1'b1;
    endcase

    byte_done_d = (state_d == STOP) && (cnt_d == CNT_LAST);
    word_done_d = byte_done_d && (byte_idx_d == 2'd3);
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      byte_idx_q  <= '0;
      txd_q       <= 1'b1;
      byte_done_q <= 1'b0;
      word_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      byte_idx_q  <= byte_idx_d;
      txd_q       <= txd_d;
      byte_done_q <= byte_done_d;
      word_done_q <= word_done_d;
    end
  end

  // NOTE: the word register carries data only; its contents are never looked
  // at outside a frame, so it is left out of reset.
  always_ff @(posedge clk) begin
    word_q <= word_d;
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign uart_txd     = txd_q;
  assign uart_tx_busy = (state_q != IDLE);
  assign byte_done    = byte_done_q;
  assign word_done    = word_done_q;

  // ---------------------------------------------------------------------------
  // Structural invariants
  // ---------------------------------------------------------------------------
  a_word_done_with_byte_done : assert property (
    @(posedge clk) disable iff (rst) word_done_q |-> byte_done_q);

  a_byte_done_in_stop : assert property (
    @(posedge clk) disable iff (rst) byte_done_q |-> (state_q == STOP));

  a_ready_only_idle : assert property (
    @(posedge clk) disable iff (rst) ready |-> !uart_tx_busy);

endmodule : uart_word_tx

// File: doc/uart_word_tx.md
UART_WORD_TX -- requirements
Module: uart_word_tx

Interface
- REQ-001 Parameter: CLK_HZ, default 50000000, system clock frequency in Hz.
- REQ-002 Parameter: BIT_RATE, default 9600, UART line rate in bits/s.
- REQ-003 Derived constant: CYCLES_PER_BIT = CLK_HZ/BIT_RATE, integer-truncated; 5208 at the default parameter values.
- REQ-004 Port: clk  in  1  sole system clock; all logic on its rising edge.
- REQ-005 Port: rst  in  1  synchronous, active-high reset.
- REQ-006 Port: uart_tx_en  in  1  transmit enable; gates acceptance of new words only.
- REQ-007 Port: word_valid  in  1  word_data holds a word to send.
- REQ-008 Port: word_data  in  32  word to serialise.
- REQ-009 Port: word_ready  out  1  block can accept a word this cycle.
- REQ-010 Port: uart_txd  out  1  UART transmit pin, idle high.
- REQ-011 Port: uart_tx_busy  out  1  a word is in progress.
- REQ-012 Port: byte_done  out  1  one-cycle pulse at the end of each byte's stop bit.
- REQ-013 Port: word_done  out  1  one-cycle pulse at the end of the 4th byte's stop bit.

Function
- REQ-014 Frame format SHALL be 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1); each bit held exactly CYCLES_PER_BIT cycles.
- REQ-015 FSM states SHALL be IDLE, START, DATA, STOP.
- REQ-016 In IDLE: word_ready = uart_tx_en; uart_txd = 1; uart_tx_busy = 0.
- REQ-017 Handshake: a word SHALL be accepted on a rising edge where word_valid & word_ready = 1; word_data is captured into an internal 32-bit register on that edge.
- REQ-018 After acceptance, word_ready SHALL be 0 and uart_tx_busy SHALL be 1 until the FSM returns to IDLE.
- REQ-019 Changes on word_data or word_valid after acceptance SHALL have no effect on the word in progress.
- REQ-020 Byte order SHALL be word[7:0], word[15:8], word[23:16], word[31:24], i.e. least-significant byte first.
- REQ-021 Transitions:
  - IDLE->START on accept; uart_txd = 0 from the cycle after the accepting edge.
  - START->DATA after CYCLES_PER_BIT cycles.
  - DATA->STOP after 8*CYCLES_PER_BIT cycles, with a 3-bit bit index counting 0..7.
  - STOP->START for the next byte, with no idle gap, after CYCLES_PER_BIT cycles when the byte index < 3.
  - STOP->IDLE after CYCLES_PER_BIT cycles when the byte index = 3.
- REQ-022 byte_done SHALL pulse high for exactly 1 cycle, on the last cycle of every stop bit.
- REQ-023 word_done SHALL pulse high for exactly 1 cycle, coincident with the 4th byte_done.
- REQ-024 Latency: from the accepting edge to the word_done cycle SHALL be 40*CYCLES_PER_BIT cycles; the byte index SHALL be 2 bits.
- REQ-025 Back-to-back words: the next accept SHALL occur no earlier than the cycle after word_done, giving a minimum idle-high gap of 1 cycle between words.
- REQ-026 Deasserting uart_tx_en mid-word SHALL NOT abort the word; the word completes normally and no further word is accepted while uart_tx_en = 0.
- REQ-027 The bit-period counter SHALL count 0..CYCLES_PER_BIT-1 and wrap to 0 at each bit boundary; there SHALL be no drift across the 40 bits of a word.
- REQ-028 Simultaneous word_valid and rst SHALL resolve to rst: no word is accepted.

Reset
- REQ-029 While rst = 1, on every clock edge the block SHALL:
  - force state = IDLE;
  - clear all counters and indices to 0;
  - set uart_txd = 1, uart_tx_busy = 0, byte_done = 0, word_done = 0.
- REQ-030 A reset asserted mid-frame SHALL abort the word immediately: uart_txd = 1 from the next edge and no byte_done/word_done for the aborted word.
- REQ-031 The shift register contents after reset are don't-care.
- REQ-032 word_ready SHALL be 0 while rst = 1 and follow REQ-016 afterwards.

Verification
Bench parameters: CLK_HZ=8, BIT_RATE=1, so CYCLES_PER_BIT=8.
- REQ-033 Reset: rst=1 for 2 cycles with uart_tx_en=1 -> uart_txd=1, busy=0, word_ready=0 during reset and 1 on the first cycle after.
- REQ-034 Single word: 32'hfb010113 -> line carries bytes 0x13, 0x01, 0x01, 0xfb; each byte has start=0, LSB first, stop=1, every bit 8 cycles; byte_done pulses every 80 cycles; word_done occurs 320 cycles after accept.
- REQ-035 Back-to-back: word_valid held high with 32'h00000000 then 32'hffffffff -> second accept is 1 cycle after the first word_done; exactly 1 idle-high cycle between frames; all 80 bits correct.
- REQ-036 Enable drop: uart_tx_en=0 during byte 1 of 32'h04812623 -> all 4 bytes complete and word_done pulses; word_ready stays 0 afterwards while word_valid=1.
- REQ-037 Reset mid-byte: rst pulsed during DATA of byte 2 -> uart_txd=1 on the next cycle, no word_done; a following word 32'h00000013 is sent correctly.
- REQ-038 Data hold: word_data changed to 32'hdeadbeef 1 cycle after accepting 32'h12345678 -> line carries 0x78, 0x56, 0x34, 0x12.
